program_loader: RTL and testbench
=================================

# program_loader

Boot-time program loader sitting directly upstream of the RISC_SPM memory and processor. It accepts a framed byte stream on a valid/ready input: start address, length, payload, then checksum. It writes the payload into the 256-word program memory through that memory's write port. While loading, it holds the processor in reset, and it releases reset only after a load completes with a matching checksum.

## Interface
Parameters:
- word_size, 8, data/stream byte width
- addr_size, 8, memory address width; memory depth is 2**addr_size

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level sampled each edge; begins a load session when not busy
- abort  in  1  terminates an active session with error
- s_data  in  word_size  stream byte
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts s_data this cycle
- mem_addr  out  addr_size  memory write address (to Memory_Unit address mux)
- mem_data  out  word_size  memory write data
- mem_write  out  1  memory write strobe, one cycle per byte
- cpu_rst_n  out  1  active-low reset to processor; 0 = processor held
- busy  out  1  session in progress
- done  out  1  last session succeeded; processor running
- error  out  1  last session failed (checksum mismatch or abort)

## Operation
- **Beat definition.** A beat is s_valid & s_ready at a rising edge. s_ready is decoded from the state register only; there is no combinational path from s_valid.
- **States.** IDLE, HDR_ADDR, HDR_LEN, DATA, CSUM, RUN, ERR.
- **IDLE.**
  - s_ready=0, cpu_rst_n=0.
  - start=1 → HDR_ADDR; busy=1, done=0, error=0.
- **HDR_ADDR** (s_ready=1). Beat loads addr_ptr=s_data → HDR_LEN.
- **HDR_LEN** (s_ready=1). Beat loads remaining=s_data, with 0 meaning 256 (9-bit counter); clears sum → DATA.
- **DATA** (s_ready=1). Each beat:
  - mem_addr<=addr_ptr, mem_data<=s_data, mem_write<=1.
  - addr_ptr increments modulo 2**addr_size (0xFF wraps to 0x00).
  - sum<=sum+s_data modulo 256.
  - remaining decrements.
  - The beat that takes remaining to 0 → CSUM.
- **mem_write.** Registered, and deasserts the cycle after any cycle with no DATA beat.
- **CSUM** (s_ready=1). On a beat:
  - s_data==sum → RUN.
  - otherwise → ERR.
- **RUN.**
  - s_ready=0, busy=0, done=1, cpu_rst_n=1.
  - start=1 → HDR_ADDR with cpu_rst_n<=0, done<=0. Reloading halts the processor.
- **ERR.**
  - s_ready=0, busy=0, error=1, cpu_rst_n=0.
  - start=1 → HDR_ADDR, error<=0.
- **start while busy.** Ignored.
- **abort.**
  - In HDR_ADDR/HDR_LEN/DATA/CSUM → ERR at the next edge.
  - A mem_write already registered for an accepted beat still completes.
  - abort has priority over a simultaneous beat; that beat is not consumed, since s_ready is still 1 but the loader treats it as dropped. The stream source must not rely on it.
  - abort in IDLE/RUN/ERR is ignored.
- **Simultaneous start and abort in RUN/ERR.** start wins.
- **Memory on abort or checksum fail.** Memory contents already written are not rolled back.

## Timing
- **Reset values:** state=IDLE, s_ready=0, mem_addr=0, mem_data=0, mem_write=0, cpu_rst_n=0, busy=0, done=0, error=0. Internal addr_ptr=0, remaining=0, sum=0.
- **Reset mid-session.** Returns immediately to reset values; the partial load is discarded (memory keeps written bytes).
- **Session start.** start sampled at edge k → busy=1 and s_ready=1 from edge k.
- **Throughput.** One beat per cycle, with no bubbles when s_valid is held high.
- **Write latency.**
  - DATA beat at edge k → mem_write=1 during cycle (k, k+1]; memory commits at edge k+1.
  - The earliest CSUM beat is edge k+1, so the last payload byte is committed no later than the edge that raises cpu_rst_n.
- **Session length.** Minimum = 3+N beats (N=1..256).
- **Status timing.** done/error/cpu_rst_n update at the same edge as the state transition.

## Test plan
- **Basic load.** Reset, start pulse, stream 0x10, 0x03, 0xA1, 0x02, 0x05, 0xA8 back-to-back → writes 0xA1@0x10, 0x02@0x11, 0x05@0x12 on three consecutive cycles. Then done=1, cpu_rst_n=1, busy=0, error=0.
- **Bad checksum.** Same frame with checksum 0xA7 → memory written, error=1, cpu_rst_n=0, done=0, state ERR; a later start clears error.
- **Wrap and length 0.**
  - Header 0xFE, 0x00, then 256 bytes of 0x01, checksum 0x00 → writes at 0xFE, 0xFF, 0x00…0xFD.
  - The 256th write is at 0xFD, then done=1.
- **Stalls.** Random s_valid gaps in DATA → one mem_write per beat, no writes during gaps, addresses contiguous, final result identical to the basic load.
- **Abort and reset mid-load.**
  - abort after 2 of 3 data beats → ERR next edge, s_ready=0, exactly 2 writes.
  - Async rst asserted mid-DATA → all outputs at reset values without waiting for a clock edge.
- **Reload from RUN.** After the basic load, a start pulse → cpu_rst_n=0 and done=0 at the next edge, and a new frame loads correctly.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time loader: parses a framed byte stream (addr, len, payload, checksum),
// writes the payload into program memory and gates the processor reset on success.
module program_loader #(
    parameter int word_size = 8,
    parameter int addr_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [word_size-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [addr_size-1:0] mem_addr,
    output logic [word_size-1:0] mem_data,
    output logic                 mem_write,
    output logic                 cpu_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [2:0] {
        IDLE, HDR_ADDR, HDR_LEN, DATA, CSUM, RUN, ERR
    } state_t;

    state_t               state_reg, state_next;
    logic [addr_size-1:0] addr_ptr_reg;
    logic [word_size:0]   remaining_reg;   // one extra bit so a zero length field means 2**word_size
    logic [word_size-1:0] sum_reg;
    logic                 beat;

    // abort wins over a simultaneous beat, so such a beat is never consumed
    assign beat = s_valid & s_ready & ~abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = HDR_ADDR;
            end
            HDR_ADDR: begin
                if (abort)     state_next = ERR;
                else if (beat) state_next = HDR_LEN;
            end
            HDR_LEN: begin
                if (abort)     state_next = ERR;
                else if (beat) state_next = DATA;
            end
            DATA: begin
                if (abort)                              state_next = ERR;
                else if (beat && remaining_reg == 'd1)  state_next = CSUM;
            end
            CSUM: begin
                if (abort)     state_next = ERR;
                else if (beat) state_next = (s_data == sum_reg) ? RUN : ERR;
            end
            RUN, ERR: begin
                if (start) state_next = HDR_ADDR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_rst_n = 1'b0;
        case (state_reg)
            HDR_ADDR, HDR_LEN, DATA, CSUM: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            RUN: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
            end
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_ptr_reg  <= '0;
            remaining_reg <= '0;
            sum_reg       <= '0;
            mem_addr      <= '0;
            mem_data      <= '0;
            mem_write     <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            if (beat) begin
                case (state_reg)
                    HDR_ADDR: addr_ptr_reg <= addr_size'(s_data);
                    HDR_LEN: begin
                        remaining_reg <= {(s_data == '0), s_data};
                        sum_reg       <= '0;
                    end
                    DATA: begin
                        mem_addr      <= addr_ptr_reg;
                        mem_data      <= s_data;
                        mem_write     <= 1'b1;
                        addr_ptr_reg  <= addr_ptr_reg + 1'b1;
                        sum_reg       <= sum_reg + s_data;
                        remaining_reg <= remaining_reg - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frames are checked against an
// expected write list and memory image computed from the frame contents.
module tb_program_loader;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_write;
    logic       cpu_rst_n;
    logic       busy;
    logic       done;
    logic       error;

    program_loader #(.word_size(8), .addr_size(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // program memory the loader drives, and the image the bench expects it to hold
    logic [7:0] ram     [256] = '{default: 8'h00};
    logic [7:0] exp_mem [256] = '{default: 8'h00};

    logic [7:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) ram[mem_addr] <= mem_data;
    end

    always @(negedge clk) begin
        if (mem_write) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
            wc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int n;
        while ($urandom_range(99) < gap_pct) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (!s_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) check("ready_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== exp_mem[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic check_status(input string tag, input bit ok);
        check({tag, "_done"},  done,      ok);
        check({tag, "_error"}, error,     !ok);
        check({tag, "_cpu"},   cpu_rst_n, ok);
        check({tag, "_busy"},  busy,      1'b0);
        check({tag, "_ready"}, s_ready,   1'b0);
    endtask

    // Drive a whole frame and compare writes, status and memory against the frame's meaning.
    task automatic run_frame(input string tag, input bit with_start, input logic [7:0] a,
                             input logic [7:0] lenf, input byte_q_t pl,
                             input logic [7:0] cs, input int gap);
        int n;
        int sum;
        bit ok;
        n   = (lenf == 8'h00) ? 256 : int'(lenf);
        sum = 0;
        for (int i = 0; i < n; i++) sum += int'(pl[i]);
        ok = ((sum % 256) == int'(cs));
        clear_log();
        if (with_start) do_start();
        send_byte(a, gap);
        send_byte(lenf, gap);
        for (int i = 0; i < n; i++) send_byte(pl[i], gap);
        send_byte(cs, gap);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) exp_mem[(int'(a) + i) % 256] = pl[i];
        check({tag, "_nwr"}, wa.size(), n);
        for (int i = 0; i < n && i < wa.size(); i++) begin
            check({tag, "_wa"}, wa[i], (int'(a) + i) % 256);
            check({tag, "_wd"}, wd[i], pl[i]);
        end
        check_status(tag, ok);
        check_mem({tag, "_mem"});
        $display("frame %s addr=%02h len=%0d csum=%02h ok=%0d writes=%0d", tag, a, n, cs, ok, wa.size());
    endtask

    initial begin
        byte_q_t pl;
        logic [7:0] a, cs;
        int n, sum;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", s_ready, 0);
        check("rst_wr",    mem_write, 0);
        check("rst_addr",  mem_addr, 0);
        check("rst_data",  mem_data, 0);
        check("rst_cpu",   cpu_rst_n, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_err",   error, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", s_ready, 0);

        // session start: busy and s_ready from the sampling edge
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy",  busy, 1);
        check("start_ready", s_ready, 1);
        pl = '{8'hA1, 8'h02, 8'h05};
        run_frame("basic", 1'b0, 8'h10, 8'h03, pl, 8'hA8, 0);
        if (wc.size() == 3) begin
            check("basic_contig1", wc[1] - wc[0], 1);
            check("basic_contig2", wc[2] - wc[0], 2);
        end else begin
            check("basic_contig_n", wc.size(), 3);
        end

        // reload from RUN halts the processor at the very next edge
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("reload_cpu",  cpu_rst_n, 0);
        check("reload_done", done, 0);
        check("reload_busy", busy, 1);
        run_frame("badcs", 1'b0, 8'h10, 8'h03, pl, 8'hA7, 0);

        // start clears error, then a wrapping full-length load
        do_start();
        check("clr_error", error, 0);
        check("clr_busy",  busy, 1);
        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(8'h01);
        run_frame("wrap", 1'b0, 8'hFE, 8'h00, pl, 8'h00, 0);
        if (wa.size() == 256) check("wrap_last", wa[255], 8'hFD);

        // randomized frames with valid gaps
        for (int f = 0; f < 8; f++) begin
            a = 8'($urandom_range(255));
            n = $urandom_range(1, 40);
            pl.delete();
            sum = 0;
            for (int i = 0; i < n; i++) begin
                pl.push_back(8'($urandom_range(255)));
                sum += int'(pl[i]);
            end
            cs = 8'(sum);
            if ($urandom_range(3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            run_frame($sformatf("rnd%0d", f), 1'b1, a, 8'(n), pl, cs, 30);
        end
        pl = '{8'hA1, 8'h02, 8'h05};
        run_frame("stall", 1'b1, 8'h10, 8'h03, pl, 8'hA8, 40);

        // abort after two of three data beats; the simultaneous third beat is dropped
        clear_log();
        do_start();
        send_byte(8'h40, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        s_valid = 1'b1;
        s_data  = 8'h33;
        abort   = 1'b1;
        @(posedge clk); #1;
        abort   = 1'b0;
        s_valid = 1'b0;
        check("abort_error", error, 1);
        check("abort_ready", s_ready, 0);
        check("abort_busy",  busy, 0);
        @(posedge clk); #1;
        check("abort_wr",  mem_write, 0);
        check("abort_nwr", wa.size(), 2);
        exp_mem[8'h40] = 8'h11;
        exp_mem[8'h41] = 8'h22;
        check_mem("abort_mem");
        $display("abort test writes=%0d error=%0d", wa.size(), error);

        // asynchronous reset mid-DATA, checked before any clock edge
        clear_log();
        do_start();
        send_byte(8'h80, 0);
        send_byte(8'h05, 0);
        send_byte(8'h99, 0);
        rst = 1'b1;
        #1;
        check("arst_wr",    mem_write, 0);
        check("arst_addr",  mem_addr, 0);
        check("arst_data",  mem_data, 0);
        check("arst_busy",  busy, 0);
        check("arst_ready", s_ready, 0);
        check("arst_cpu",   cpu_rst_n, 0);
        check("arst_done",  done, 0);
        check("arst_err",   error, 0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("arst_nwr", wa.size(), 0);
        check_mem("arst_mem");
        $display("async reset test writes=%0d", wa.size());

        run_frame("after_rst", 1'b1, 8'h10, 8'h03, pl, 8'hA8, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
